// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter feeding one registered output beat tagged with the winner's ID.
// One cycle from accept to out_*; in_ready is held low while the output register is full and stalled.
module rr_mux_arbiter #(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_valid,
   input  logic [N*W-1:0]   in_data,
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [IDW-1:0]   out_id,
   input  logic             out_ready
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win_id;
   logic           has_win;
   logic           load;
   logic [IDW:0]   cand;
   logic [IDW-1:0] cand_id;

   assign load = ~out_valid | out_ready;

   // Search starts at ptr and wraps; the extra sum bit keeps ptr+k from overflowing before the wrap.
   always_comb begin
      has_win = 1'b0;
      win_id  = '0;
      cand    = '0;
      cand_id = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
         cand_id = cand[IDW-1:0];
         if (!has_win && in_valid[cand_id]) begin
            has_win = 1'b1;
            win_id  = cand_id;
         end
      end
   end

   assign in_ready = (rst_n && load && has_win) ? (N'(1) << win_id) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (has_win) begin
            out_valid <= 1'b1;
            out_data  <= in_data[win_id*W +: W];
            out_id    <= win_id;
            ptr       <= (win_id == IDW'(N-1)) ? '0 : win_id + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expectations, then random traffic vs a model.
module tb_rr_mux_arbiter;
   localparam int N = 4, W = 8, IDW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     in_valid;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [IDW-1:0]   out_id;
   logic             out_ready;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state: what the output register and priority pointer must hold.
   bit         m_known = 1'b0;
   bit         m_valid;
   int         m_data;
   int         m_id;
   int         m_ptr;

   rr_mux_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs only change at posedge+1, so the falling edge sees what the next rising edge will use.
   always @(negedge clk) begin
      int g;
      int idx;
      bit ld;
      logic [N-1:0] exp_rdy;
      if (m_known) begin
         chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
         chk("m_out_data", {24'b0, out_data}, m_data);
         chk("m_out_id", {30'b0, out_id}, m_id);
      end
      ld = !m_valid || out_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (g < 0 && in_valid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (rst_n && m_known && ld && g >= 0) exp_rdy[g] = 1'b1;
      if (m_known || !rst_n) chk("m_in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
      if (!rst_n) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_data  = 0;
         m_id    = 0;
         m_ptr   = 0;
      end else if (m_known && ld) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = int'(in_data[g*W +: W]);
            m_id    = g;
            m_ptr   = (g + 1) % N;
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input bit v, input int d, input int id);
      chk({nm, "_valid"}, {31'b0, out_valid}, {31'b0, v});
      chk({nm, "_data"}, {24'b0, out_data}, d);
      chk({nm, "_id"}, {30'b0, out_id}, id);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
      out_ready = 1'b1;

      // Reset held for two edges with every requester asking.
      edge_settle();
      chk_out("rst1", 1'b0, 0, 0);
      chk("rst1_in_ready", {28'b0, in_ready}, 32'h0);
      edge_settle();
      chk_out("rst2", 1'b0, 0, 0);
      chk("rst2_in_ready", {28'b0, in_ready}, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {28'b0, in_ready}, 32'h1);

      // Full sweep; ends right after the grant to requester 2.
      for (int i = 0; i < 11; i++) begin
         edge_settle();
         chk_out("sweep", 1'b1, 8'h11 * ((i % 4) + 1), i % 4);
      end

      // Only 0 and 1 valid with ptr at 3: 3 is skipped, no bubble.
      in_valid = 4'b0011;
      edge_settle(); chk_out("wrap0", 1'b1, 8'h11, 0);
      edge_settle(); chk_out("wrap1", 1'b1, 8'h22, 1);
      edge_settle(); chk_out("wrap2", 1'b1, 8'h11, 0);

      // Backpressure: beat from 1 is held, pointer frozen at 2.
      in_valid = 4'b0110;
      edge_settle(); chk_out("bp_load", 1'b1, 8'h22, 1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge_settle();
         chk_out("bp_hold", 1'b1, 8'h22, 1);
         chk("bp_in_ready", {28'b0, in_ready}, 32'h0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", {28'b0, in_ready}, 32'h4);
      edge_settle(); chk_out("bp_next", 1'b1, 8'h33, 2);

      // Drain to empty: data and id stay with the last beat.
      in_valid = 4'b1000;
      in_data  = {8'hA5, 8'h33, 8'h22, 8'h11};
      edge_settle(); chk_out("drain_load", 1'b1, 8'hA5, 3);
      in_valid = 4'b0000;
      edge_settle(); chk_out("drain_empty", 1'b0, 8'hA5, 3);

      // Reset while a stalled beat is held, with ptr at 1.
      in_valid = 4'b0001;
      edge_settle(); chk_out("mr_load", 1'b1, 8'h11, 0);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      edge_settle(); chk_out("mr_stall", 1'b1, 8'h11, 0);
      rst_n = 1'b0;
      #1;
      chk("mr_in_ready", {28'b0, in_ready}, 32'h0);
      edge_settle(); chk_out("mr_rst", 1'b0, 0, 0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'b1001;
      edge_settle(); chk_out("mr_ptr0", 1'b1, 8'h11, 0);
      in_valid = 4'b1000;
      edge_settle(); chk_out("mr_g3", 1'b1, 8'hA5, 3);
      in_valid = 4'b1001;
      edge_settle(); chk_out("mr_wrap", 1'b1, 8'h11, 0);

      // Random traffic; the falling-edge model checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         in_valid  = N'($urandom);
         in_data   = {$urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         edge_settle();
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 mux datapath among N valid/ready requesters.
- Each cycle it picks one requesting input, steers its data through the mux, and captures the result in a single output register that carries the winner's ID.
- Sits between several producer blocks and one shared downstream consumer.
- Fairness is strict round-robin: after a requester is granted, priority moves to the next index.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- W, 8, data width in bits.
- IDW, $clog2(N), width of the requester ID field (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  N  bit i set: requester i presents data.
- in_data  input  N*W  requester i data in bits [i*W +: W].
- in_ready  output  N  one-hot or zero; bit i set: requester i is accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  data of the held beat.
- out_id  output  IDW  index of the requester that produced the held beat.
- out_ready  input  1  consumer accepts the held beat this cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_id=0.
  - Priority pointer ptr=0.
  - in_ready is forced to 0 while rst_n=0.
  - Reset mid-transfer discards the held beat. No handshake completes in the reset cycle.
- Load enable: load = ~out_valid | out_ready (register is empty or drains this cycle).
- Grant selection (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping from N-1 to 0.
  - The first set bit is the winner g.
  - If in_valid is all zero, there is no winner.
- in_ready:
  - in_ready[g]=1 only when load=1 and a winner exists.
  - All other bits are 0. in_ready is never multi-hot.
- Transfer on the clk edge where load=1 and a winner exists:
  - out_data <= in_data[g]; out_id <= g; out_valid <= 1.
  - ptr <= (g==N-1) ? 0 : g+1.
- Drain with no winner: when out_ready=1 and out_valid=1 with no winner, out_valid <= 0. out_data and out_id hold their values.
- Stall: when out_valid=1 and out_ready=0:
  - All registers hold; in_ready=0.
  - ptr does not move, even if in_valid changes.
- Latency: a beat accepted at edge k is visible at out_* after edge k. Sustained throughput is 1 beat/cycle when out_ready stays 1.
- Simultaneous drain and load: out_ready=1 and a winner present means the old beat leaves and the new beat loads on the same edge, with no bubble.
- Requester rules:
  - A requester must hold in_valid and in_data stable until it sees in_ready.
  - The arbiter does not check this.
  - Dropping in_valid without a grant is allowed and simply removes the requester from the next search.
- Fairness: with all N requesters continuously valid and out_ready=1, the grant order is ptr, ptr+1, …, wrapping. Each requester is served exactly once in any N consecutive transfers.
- The internal N:1 data mux is a plain indexed select on g. No priority encoding leaks into the data path.
- out_data and out_id change only on a transfer. They are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_id=0. On the first cycle after release, in_ready=4'b0001.
- Round-robin sweep: in_valid=4'b1111, in_data={8'h44,8'h33,8'h22,8'h11}, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3. out_data follows 11,22,33,44,… with out_valid=1 every cycle after the first.
- Sparse wrap: after a grant to 2 (ptr=3), set in_valid=4'b0011 -> grant 0, then 1, then 0. Requester 3 is skipped, with no idle cycle between transfers.
- Backpressure: in_valid=4'b0110, out_ready=0 for 3 cycles after the first load -> out_id=1 and out_data held; in_ready=0; ptr stays 2. Set out_ready=1 -> next out_id=2.
- Drain to empty: single beat from requester 3 (8'hA5), then in_valid=0 with out_ready=1 -> out_valid drops to 0 the next cycle; out_data remains 8'hA5.
- Mid-operation reset: out_valid=1 with out_ready=0, assert rst_n=0 for 1 cycle -> out_valid=0 and ptr=0. The next grant with in_valid=4'b1000 goes to requester 3 and then wraps to 0.
